// File: rtl/dfoc_adc_reader_2ph.sv
// Phase-current reader for the 2-phase DFOC core.
// Runs one SPI frame of a dual-channel simultaneous ADC per start pulse.
module dfoc_adc_reader_2ph #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int DATA_BITS  = 12,
  parameter int OUT_SHIFT  = 4,
  parameter int CS_SETUP   = 2,
  parameter int QUIET      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] off_a,
  input  logic [15:0] off_b,
  input  logic        sdata_a,
  input  logic        sdata_b,
  input  logic        ovr_clr,
  output logic        cs_n,
  output logic        sclk,
  output logic [15:0] ia,
  output logic [15:0] ib,
  output logic        rdy,
  output logic        busy,
  output logic        overrun
);

  localparam int CW = 16;
  localparam int BW = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_CONV,
    S_QUIET
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          hc_q, hc_d;
  logic [BW-1:0]          bidx_q, bidx_d;
  logic                   cs_n_d, sclk_d;
  logic                   smp;
  logic                   keep;
  logic [DATA_BITS-1:0]   sh_a_q, sh_b_q;

  // Offset-binary to two's complement, scale, subtract offset, saturate.
  // Bits 17..15 all equal means the 18-bit result fits in 16 bits.
  function automatic logic [15:0] scale(
    input logic [DATA_BITS-1:0] raw,
    input logic [15:0]          off
  );
    logic [17:0] s, o, v;
    s = {{(18-DATA_BITS+1){~raw[DATA_BITS-1]}},
         raw[DATA_BITS-2:0]};
    o = {{2{off[15]}}, off};
    v = (s << OUT_SHIFT) - o;
    if (!v[17] && (v[16:15] != 2'b00))
      scale = 16'h7FFF;
    else if (v[17] && (v[16:15] != 2'b11))
      scale = 16'h8000;
    else
      scale = v[15:0];
  endfunction

  assign keep = (bidx_q >= BW'(LEAD_BITS)) &&
                (bidx_q <  BW'(LEAD_BITS + DATA_BITS));

  // Next-state logic and next values of the serial-bus pins.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    bidx_d  = bidx_q;
    cs_n_d  = cs_n;
    sclk_d  = sclk;
    smp     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          hc_d    = '0;
          cs_n_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (hc_q == CW'(CS_SETUP - 1)) begin
          state_d = S_SHIFT;
          hc_d    = '0;
          bidx_d  = '0;
          sclk_d  = 1'b0;
        end else begin
          hc_d = hc_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (hc_q == CW'(CLK_DIV - 1)) begin
          hc_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
            smp    = 1'b1;
          end else if (bidx_q == BW'(FRAME_BITS - 1)) begin
            state_d = S_CONV;
            cs_n_d  = 1'b1;
          end else begin
            bidx_d = bidx_q + BW'(1);
            sclk_d = 1'b0;
          end
        end else begin
          hc_d = hc_q + CW'(1);
        end
      end
      S_CONV: begin
        state_d = S_QUIET;
        hc_d    = '0;
      end
      S_QUIET: begin
        if (hc_q == CW'(QUIET - 1))
          state_d = S_IDLE;
        else
          hc_d = hc_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, bus pins and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hc_q    <= '0;
      bidx_q  <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b1;
      rdy     <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bidx_q  <= bidx_d;
      cs_n    <= cs_n_d;
      sclk    <= sclk_d;
      rdy     <= (state_d == S_CONV);
      busy    <= (state_d != S_IDLE);
      if (start && (state_q != S_IDLE))
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

  // Sample capture and result registers; results and offsets
  // are taken on the edge that enters CONV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a_q <= '0;
      sh_b_q <= '0;
      ia     <= '0;
      ib     <= '0;
    end else begin
      if (smp && keep) begin
        sh_a_q <= {sh_a_q[DATA_BITS-2:0], sdata_a};
        sh_b_q <= {sh_b_q[DATA_BITS-2:0], sdata_b};
      end
      if (state_d == S_CONV) begin
        ia <= scale(sh_a_q, off_a);
        ib <= scale(sh_b_q, off_b);
      end
    end
  end

endmodule
